xpb_table_gen: RTL and testbench

- Runtime writer for the xpb reduction tables that the modular-square datapath reads through a 5-bit digit index.
- On `start`, it captures a modulus N and a base residue B. It then writes T[j] = j·B mod N for j = 0 .. 2^DIGIT_BITS−1 into an external table RAM, one entry per write strobe.
- It replaces fixed ROM contents when the modulus changes, and sits between the host/config loader and the xpb table storage.

---
 rtl/xpb_table_gen_pkg.sv | 24 ++
 rtl/xpb_table_gen_mod_add_reduce.sv | 29 ++
 rtl/xpb_table_gen.sv | 136 +++++++++++++
 tb/tb_xpb_table_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xpb_table_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package     : xpb_pkg
// Description : Shared sizing defaults and FSM state encoding for the xpb
//               reduction-table generator.
// Revision    : 1.0 - initial release
// ============================================================================
package xpb_pkg;

    localparam int XPB_NUM_BITS    = 1024;
    localparam int XPB_DIGIT_BITS  = 5;
    localparam int XPB_NUM_ENTRIES = 1 << XPB_DIGIT_BITS;

    // Explicit 3-bit encoding keeps state values stable across tools.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ZERO = 3'd1,
        ST_ADD  = 3'd2,
        ST_RED  = 3'd3,
        ST_DONE = 3'd4
    } xpb_state_t;

endpackage : xpb_pkg
`default_nettype wire

// File: rtl/xpb_table_gen_mod_add_reduce.sv
`default_nettype none
// ============================================================================
// Module      : mod_add_reduce
// Description : Single conditional subtraction of a modulus from a sum that is
//               known to be below 2N. Returns the reduced value and whether
//               the subtraction was taken.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_add_reduce
    import xpb_pkg::*;
#(
    parameter int NUM_BITS = XPB_NUM_BITS
) (
    input  logic [NUM_BITS:0]   sum_i,
    input  logic [NUM_BITS-1:0] n_i,
    output logic [NUM_BITS-1:0] r_o,
    output logic                ge_o
);

    logic [NUM_BITS-1:0] w_diff;

    assign ge_o   = (sum_i >= {1'b0, n_i});
    // When sum >= N the true difference is below N, so the low bits of the
    // subtraction are exact even though the carry bit of sum is dropped.
    assign w_diff = sum_i[NUM_BITS-1:0] - n_i;
    assign r_o    = ge_o ? w_diff : sum_i[NUM_BITS-1:0];

endmodule : mod_add_reduce
`default_nettype wire

// File: rtl/xpb_table_gen.sv
`default_nettype none
// ============================================================================
// Module      : xpb_table_gen
// Description : Writes T[j] = j*B mod N for j = 0 .. 2^DIGIT_BITS-1 into an
//               external table RAM, one entry per write strobe, using a
//               running accumulator (add B, reduce once) per entry.
// Revision    : 1.0 - initial release
// ============================================================================
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int NUM_BITS   = XPB_NUM_BITS,
    parameter int DIGIT_BITS = XPB_DIGIT_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_BITS-1:0]   modulus,
    input  logic [NUM_BITS-1:0]   base,
    output logic                  busy,
    output logic                  wr_en,
    output logic [DIGIT_BITS-1:0] wr_addr,
    output logic [NUM_BITS-1:0]   wr_data,
    output logic                  done,
    output logic                  err
);

    localparam logic [DIGIT_BITS-1:0] LAST_IDX = {DIGIT_BITS{1'b1}};

    xpb_state_t            state_q, state_d;
    logic [DIGIT_BITS-1:0] idx_q,   idx_d;
    logic [NUM_BITS-1:0]   acc_q,   acc_d;
    logic [NUM_BITS:0]     sum_q,   sum_d;
    logic [NUM_BITS-1:0]   n_q,     n_d;
    logic [NUM_BITS-1:0]   b_q,     b_d;
    logic                  err_q,   err_d;

    logic [NUM_BITS-1:0]   w_red_r;
    logic                  w_red_ge;
    logic [NUM_BITS-1:0]   w_entry;

    mod_add_reduce #(
        .NUM_BITS (NUM_BITS)
    ) u_reduce (
        .sum_i (sum_q),
        .n_i   (n_q),
        .r_o   (w_red_r),
        .ge_o  (w_red_ge)
    );

    // Below N the sum passes straight through; the top carry bit is then 0.
    assign w_entry = w_red_ge ? w_red_r : sum_q[NUM_BITS-1:0];

    // Next-state and datapath update for the table-walk FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        n_d     = n_q;
        b_d     = b_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d   = modulus;
                    b_d   = base;
                    idx_d = '0;
                    acc_d = '0;
                    // B >= N (which covers N == 0) cannot be tabulated.
                    if (base >= modulus) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ZERO;
                    end
                end
            end
            ST_ZERO: begin
                idx_d   = DIGIT_BITS'(1);
                state_d = ST_ADD;
            end
            ST_ADD: begin
                sum_d   = {1'b0, acc_q} + {1'b0, b_q};
                state_d = ST_RED;
            end
            ST_RED: begin
                acc_d = w_entry;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_ADD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            n_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            n_q     <= n_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    // Outputs depend on registered state only.
    assign busy    = (state_q != ST_IDLE);
    assign wr_en   = (state_q == ST_ZERO) || (state_q == ST_RED);
    assign wr_addr = (state_q == ST_RED) ? idx_q   : '0;
    assign wr_data = (state_q == ST_RED) ? w_entry : '0;
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;

endmodule : xpb_table_gen
`default_nettype wire

// File: tb/tb_xpb_table_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_xpb_table_gen
// Description : Directed self-checking bench for xpb_table_gen at 16-bit and
//               1024-bit widths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xpb_table_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        start16;
    logic [15:0] mod16, base16, data16;
    logic        busy16, wr_en16, done16, err16;
    logic [4:0]  addr16;

    // 1024-bit instance
    logic          start1k;
    logic [1023:0] mod1k, base1k, data1k;
    logic          busy1k, wr_en1k, done1k, err1k;
    logic [4:0]    addr1k;

    xpb_table_gen #(.NUM_BITS(16), .DIGIT_BITS(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .modulus(mod16), .base(base16),
        .busy(busy16), .wr_en(wr_en16), .wr_addr(addr16), .wr_data(data16),
        .done(done16), .err(err16)
    );

    xpb_table_gen #(.NUM_BITS(1024), .DIGIT_BITS(5)) dut1k (
        .clk(clk), .rst_n(rst_n), .start(start1k), .modulus(mod1k), .base(base1k),
        .busy(busy1k), .wr_en(wr_en1k), .wr_addr(addr1k), .wr_data(data1k),
        .done(done1k), .err(err1k)
    );

    int errors = 0;
    int checks = 0;

    // Observations collected by the capture tasks (cycle c = between E(c-1) and E(c)).
    int            nwr, done_cnt, done_cyc, busy_cnt, busy_last, err_c1;
    int            wa   [64];
    int            wcyc [64];
    logic [1023:0] wd   [64];

    task automatic clear_obs();
        nwr = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_last = -1; err_c1 = -1;
    endtask

    task automatic cap16(input logic [15:0] n, input logic [15:0] b, input bit inj_start);
        @(posedge clk); #1;
        mod16 = n; base16 = b; start16 = 1'b1;
        @(posedge clk); #1;               // E0 has passed
        start16 = 1'b0; mod16 = ~n; base16 = b ^ 16'h5a5a;
        clear_obs();
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (wr_en16) begin
                if (nwr < 64) begin
                    wa[nwr] = int'(addr16); wd[nwr] = {1008'b0, data16}; wcyc[nwr] = c;
                end
                nwr++;
            end
            if (done16) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
            if (busy16) begin busy_cnt++; busy_last = c; end
            if (c == 1) err_c1 = int'(err16);
            start16 = inj_start && (c == 10);   // high across E10 only
        end
    endtask

    task automatic cap1k(input logic [1023:0] n, input logic [1023:0] b);
        @(posedge clk); #1;
        mod1k = n; base1k = b; start1k = 1'b1;
        @(posedge clk); #1;
        start1k = 1'b0;
        for (int k = 0; k < 32; k++) begin
            mod1k[k*32 +: 32] = $urandom; base1k[k*32 +: 32] = $urandom;
        end
        clear_obs();
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (wr_en1k) begin
                if (nwr < 64) begin
                    wa[nwr] = int'(addr1k); wd[nwr] = data1k; wcyc[nwr] = c;
                end
                nwr++;
            end
            if (done1k) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
            if (busy1k) begin busy_cnt++; busy_last = c; end
            if (c == 1) err_c1 = int'(err1k);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start16 = 0; mod16 = 0; base16 = 0;
        start1k = 0; mod1k = '0; base1k = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy16, wr_en16, done16, err16, addr16, data16} !== 25'd0) begin
            errors++; $display("FAIL reset16 got=%h want=0", {busy16, wr_en16, done16, err16, addr16, data16});
        end
        checks++;
        if ({busy1k, wr_en1k, done1k, err1k, addr1k} !== 9'd0 || data1k !== '0) begin
            errors++; $display("FAIL reset1k busy=%b wr_en=%b done=%b err=%b", busy1k, wr_en1k, done1k, err1k);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Shared checks of a complete valid 16-bit run against j*B mod N.
    task automatic test_seq16(input string tag, input int n, input int b);
        checks++;
        if (nwr !== 32) begin errors++; $display("FAIL %s nwr got=%0d want=32", tag, nwr); end
        for (int j = 0; j < 32; j++) begin
            checks++;
            if (wa[j] !== j || wcyc[j] !== 2*j+1 || wd[j] !== 1024'((j*b) % n)) begin
                errors++;
                $display("FAIL %s entry%0d got addr=%0d cyc=%0d data=%0d want addr=%0d cyc=%0d data=%0d",
                         tag, j, wa[j], wcyc[j], wd[j][15:0], j, 2*j+1, (j*b) % n);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 64) begin
            errors++; $display("FAIL %s done got cnt=%0d cyc=%0d want cnt=1 cyc=64", tag, done_cnt, done_cyc);
        end
        checks++;
        if (busy_cnt !== 64 || busy_last !== 64) begin
            errors++; $display("FAIL %s busy got cnt=%0d last=%0d want 64/64", tag, busy_cnt, busy_last);
        end
    endtask

    task automatic test_basic();
        int hand [14] = '{0, 5, 10, 2, 7, 12, 4, 9, 1, 6, 11, 3, 8, 0};
        cap16(16'd13, 16'd5, 1'b0);
        test_seq16("n13b5", 13, 5);
        for (int j = 0; j < 14; j++) begin
            checks++;
            if (wd[j] !== 1024'(hand[j])) begin
                errors++; $display("FAIL hand5_%0d got=%0d want=%0d", j, wd[j][15:0], hand[j]);
            end
        end
        checks++;
        if (wd[31] !== 1024'd12) begin errors++; $display("FAIL addr31 got=%0d want=12", wd[31][15:0]); end
    endtask

    task automatic test_edges();
        cap16(16'd13, 16'd0, 1'b0);
        test_seq16("b0", 13, 0);
        cap16(16'd13, 16'd12, 1'b0);
        test_seq16("b12", 13, 12);
        checks++;
        if (wd[1] !== 1024'd12 || wd[13] !== 1024'd0 || wd[14] !== 1024'd12) begin
            errors++; $display("FAIL b12pts got=%0d,%0d,%0d want=12,0,12", wd[1][15:0], wd[13][15:0], wd[14][15:0]);
        end
    endtask

    task automatic test_error();
        cap16(16'd13, 16'd13, 1'b0);
        checks++;
        if (nwr !== 0 || done_cnt !== 1 || done_cyc !== 1 || busy_cnt !== 1 || err_c1 !== 1) begin
            errors++; $display("FAIL err_bge got nwr=%0d done=%0d@%0d busy=%0d err=%0d want 0,1@1,1,1",
                               nwr, done_cnt, done_cyc, busy_cnt, err_c1);
        end
        checks++;
        if (err16 !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", err16); end
        cap16(16'd13, 16'd7, 1'b0);
        checks++;
        if (err_c1 !== 0 || err16 !== 1'b0) begin
            errors++; $display("FAIL err_clear got c1=%0d end=%b want 0", err_c1, err16);
        end
        test_seq16("after_err", 13, 7);
        cap16(16'd0, 16'd0, 1'b0);
        checks++;
        if (nwr !== 0 || done_cyc !== 1 || err_c1 !== 1 || err16 !== 1'b1) begin
            errors++; $display("FAIL err_n0 got nwr=%0d done@%0d err=%0d/%b want 0,1,1", nwr, done_cyc, err_c1, err16);
        end
    endtask

    task automatic test_back_to_back();
        cap16(16'd13, 16'd5, 1'b1);
        test_seq16("start_busy", 13, 5);
    endtask

    task automatic test_midrun_reset();
        int stray;
        @(posedge clk); #1;
        mod16 = 16'd13; base16 = 16'd5; start16 = 1'b1;
        @(posedge clk); #1;               // E0
        start16 = 1'b0;
        repeat (20) @(posedge clk);       // E20
        #1;
        checks++;
        if (busy16 !== 1'b1) begin errors++; $display("FAIL pre_rst_busy got=%b want=1", busy16); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_en16, busy16, done16, err16} !== 4'b0) begin
            errors++; $display("FAIL async_rst got=%b want=0000", {wr_en16, busy16, done16, err16});
        end
        stray = 0;
        repeat (4) begin @(negedge clk); if (wr_en16 || busy16) stray++; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (wr_en16 || busy16) stray++; end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL rst_quiet got=%0d active cycles want=0", stray); end
        cap16(16'd13, 16'd5, 1'b0);
        test_seq16("post_rst", 13, 5);
    endtask

    task automatic test_wide();
        logic [1023:0] n, b;
        logic [1029:0] p;
        for (int k = 0; k < 32; k++) begin
            n[k*32 +: 32] = $urandom; b[k*32 +: 32] = $urandom;
        end
        n[0] = 1'b1; n[1023] = 1'b1;
        b = b % n;
        cap1k(n, b);
        checks++;
        if (nwr !== 32 || done_cyc !== 64 || busy_cnt !== 64) begin
            errors++; $display("FAIL wide_ctl got nwr=%0d done@%0d busy=%0d want 32,64,64", nwr, done_cyc, busy_cnt);
        end
        for (int j = 0; j < 32; j++) begin
            p = (1030'(j) * {6'b0, b}) % {6'b0, n};
            checks++;
            if (wa[j] !== j || wd[j] !== p[1023:0]) begin
                errors++; $display("FAIL wide_entry%0d got addr=%0d low=%h want addr=%0d low=%h",
                                   j, wa[j], wd[j][63:0], j, p[63:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_error();
        test_back_to_back();
        test_midrun_reset();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_xpb_table_gen
`default_nettype wire
